// File: rtl/scsi_target_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scsi_target_sequencer
// Purpose  : SCSI target-side phase sequencer. Handles selection, phase
//            settle, REQ/ACK byte handshakes through a shared byte FIFO,
//            bus-free and SCSI bus reset.
// Options  : define SCSI_ACK_TIMEOUT_EN to add the ACK watchdog
//            (limit TIMEOUT_CYCLES, reported on mcu_timeout).
// Revision : 1.0 - initial release
// ============================================================================
module scsi_target_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        mcu_CLK,
  input  logic        mcu_RST,
  input  logic        scsi_nSEL,
  input  logic        scsi_nACK,
  input  logic        scsi_nRST,
  input  logic [7:0]  scsi_nDATA_in,
  output logic        scsi_nBSY,
  output logic        scsi_nREQ,
  output logic        scsi_nMSG,
  output logic        scsi_CnD,
  output logic        scsi_InO,
  output logic [7:0]  scsi_nDATA_out,
  output logic        scsi_nDATA_oe,
  input  logic [2:0]  mcu_phase,
  input  logic [15:0] mcu_xfer_len,
  input  logic        mcu_start,
  input  logic        mcu_release,
  input  logic [7:0]  mcu_wr_data,
  input  logic        mcu_wr_valid,
  output logic        mcu_wr_ready,
  output logic [7:0]  mcu_rd_data,
  output logic        mcu_rd_valid,
  input  logic        mcu_rd_ready,
  output logic        mcu_selected,
  output logic        mcu_done,
  output logic        mcu_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECTED  = 3'd1,
    S_SETTLE    = 3'd2,
    S_REQ       = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_NACK = 3'd5,
    S_BUS_FREE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_sync_q, ack_sync_q, rst_sync_q;
  logic          nbsy_q, nbsy_d, nreq_q, nreq_d;
  logic          cnd_q, cnd_d, ino_q, ino_d, nmsg_q, nmsg_d;
  logic [7:0]    ndata_q, ndata_d;
  logic          oe_q, oe_d, sel_q, sel_d, done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic sel_s, ack_s, rst_s;
  logic fifo_full, fifo_empty, push, pop, seq_push, seq_pop, mcu_push, mcu_pop;
  logic go_free, wd_hit;
  logic [7:0] push_data;

  assign sel_s = sel_sync_q[1];
  assign ack_s = ack_sync_q[1];
  assign rst_s = rst_sync_q[1];

  // Two-flop synchronisers for the asynchronous SCSI control inputs
  always_ff @(posedge mcu_CLK or posedge mcu_RST) begin
    if (mcu_RST) begin
      sel_sync_q <= 2'b11;
      ack_sync_q <= 2'b11;
      rst_sync_q <= 2'b11;
    end else begin
      sel_sync_q <= {sel_sync_q[0], scsi_nSEL};
      ack_sync_q <= {ack_sync_q[0], scsi_nACK};
      rst_sync_q <= {rst_sync_q[0], scsi_nRST};
    end
  end

  // FIFO direction follows the latched InO: MCU fills it for target-driven
  // phases, the bus fills it and the MCU drains it for host-driven phases.
  assign fifo_full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign mcu_wr_ready = ~fifo_full;
  assign mcu_rd_valid = ino_q & ~fifo_empty & (state_q != S_BUS_FREE);
  assign mcu_rd_data  = mem_q[rd_ptr_q];
  assign mcu_push     = ~ino_q & mcu_wr_valid & ~fifo_full;
  assign mcu_pop      = mcu_rd_valid & mcu_rd_ready;
  assign push         = mcu_push | seq_push;
  assign pop          = mcu_pop | seq_pop;
  assign push_data    = seq_push ? ~scsi_nDATA_in : mcu_wr_data;

  // FIFO storage (no reset needed; validity is tracked by count_q)
  always_ff @(posedge mcu_CLK) begin
    if (push && state_q != S_BUS_FREE) mem_q[wr_ptr_q] <= push_data;
  end

  // FIFO pointers and occupancy; BUS_FREE flushes
  always_ff @(posedge mcu_CLK or posedge mcu_RST) begin
    if (mcu_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (state_q == S_BUS_FREE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

`ifdef SCSI_ACK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic          timeout_q;

  assign wd_hit = (state_q == S_WAIT_ACK || state_q == S_WAIT_NACK) &&
                  (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign mcu_timeout = timeout_q;

  // ACK watchdog: counts while waiting on the host, restarts on any state change
  always_ff @(posedge mcu_CLK or posedge mcu_RST) begin
    if (mcu_RST) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_hit & rst_s;
      if (state_d != state_q) wd_q <= '0;
      else if (state_q == S_WAIT_ACK || state_q == S_WAIT_NACK) wd_q <= wd_q + WW'(1);
      else wd_q <= '0;
    end
  end
`else
  assign wd_hit      = 1'b0;
  // Constant-false compare keeps the limit parameter referenced in this build
  assign mcu_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and registered-output logic; bus reset has the last word
  always_comb begin
    state_d  = state_q;
    nbsy_d   = nbsy_q;
    nreq_d   = nreq_q;
    cnd_d    = cnd_q;
    ino_d    = ino_q;
    nmsg_d   = nmsg_q;
    ndata_d  = ndata_q;
    oe_d     = oe_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    seq_push = 1'b0;
    seq_pop  = 1'b0;
    go_free  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!sel_s) begin
          nbsy_d  = 1'b0;
          sel_d   = 1'b1;
          state_d = S_SELECTED;
        end
      end
      S_SELECTED: begin
        if (mcu_start) begin
          cnd_d    = mcu_phase[2];
          ino_d    = mcu_phase[1];
          nmsg_d   = ~mcu_phase[0];
          oe_d     = ~mcu_phase[1];
          cnt_d    = mcu_xfer_len;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else if (mcu_release) begin
          go_free = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_REQ;
        else settle_d = settle_q + SW'(1);
      end
      S_REQ: begin
        if (!ino_q) begin
          if (!fifo_empty) begin
            ndata_d = ~mcu_rd_data;
            seq_pop = 1'b1;
            nreq_d  = 1'b0;
            state_d = S_WAIT_ACK;
          end
        end else if (!fifo_full) begin
          nreq_d  = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!ack_s) begin
          seq_push = ino_q;
          nreq_d   = 1'b1;
          state_d  = S_WAIT_NACK;
        end
      end
      S_WAIT_NACK: begin
        if (ack_s) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = S_SELECTED;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_BUS_FREE: begin
        sel_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wd_hit || !rst_s) go_free = 1'b1;
    if (go_free) begin
      state_d  = S_BUS_FREE;
      seq_push = 1'b0;
      seq_pop  = 1'b0;
      done_d   = 1'b0;
      nbsy_d   = 1'b1;
      nreq_d   = 1'b1;
      cnd_d    = 1'b1;
      ino_d    = 1'b1;
      nmsg_d   = 1'b1;
      ndata_d  = 8'hFF;
      oe_d     = 1'b0;
      cnt_d    = cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge mcu_CLK or posedge mcu_RST) begin
    if (mcu_RST) begin
      state_q  <= S_IDLE;
      nbsy_q   <= 1'b1;
      nreq_q   <= 1'b1;
      cnd_q    <= 1'b1;
      ino_q    <= 1'b1;
      nmsg_q   <= 1'b1;
      ndata_q  <= 8'hFF;
      oe_q     <= 1'b0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 16'd0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      nbsy_q   <= nbsy_d;
      nreq_q   <= nreq_d;
      cnd_q    <= cnd_d;
      ino_q    <= ino_d;
      nmsg_q   <= nmsg_d;
      ndata_q  <= ndata_d;
      oe_q     <= oe_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  assign scsi_nBSY      = nbsy_q;
  assign scsi_nREQ      = nreq_q;
  assign scsi_nMSG      = nmsg_q;
  assign scsi_CnD       = cnd_q;
  assign scsi_InO       = ino_q;
  assign scsi_nDATA_out = ndata_q;
  assign scsi_nDATA_oe  = oe_q;
  assign mcu_selected   = sel_q;
  assign mcu_done       = done_q;

endmodule
`default_nettype wire
